pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  in  1  core clock; all state updates on posedge clk.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 ID_Rs, ID_Rt  in  5 each  source register numbers of the instruction in ID.
REQ-004 EXE_Dst  in  5  destination register of the instruction in EXE.
REQ-005 EXE_IsLoad  in  1  the instruction in EXE is a load.
REQ-006 EXE_BranchTaken  in  1  the branch or jump in EXE resolved taken.
REQ-007 EXE_DivStart  in  1  a multicycle divide is in EXE; level signal, held until it leaves EXE.
REQ-008 Div_Done  in  1  the divider result is valid this cycle.
REQ-009 DCache_Req, DCache_Ready  in  1 each  MEM-stage access pending; access completes this cycle.
REQ-010 MEM_ExcValid  in  1  the instruction in MEM raised an exception.
REQ-011 Cnt_Clr  in  1  synchronous clear of Stall_Cnt.
REQ-012 PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr  out  1 each  pipeline-register write enables.
REQ-013 ID_Flush, EXE_Flush, MEM_Flush, WB_Flush  out  1 each  pipeline-register flushes; a flush overrides the write enable in the register.
REQ-014 Ctrl_State  out  2  current state encoding: RUN=0, MEM_WAIT=1, DIV_WAIT=2, EXC_FLUSH=3.
REQ-015 Stall_Cnt  out  16  count of cycles with PC_Wr=0.

Function
REQ-016 All outputs shall be combinational from the state and inputs, except Ctrl_State and Stall_Cnt, which are registers.
REQ-017 Default outputs: all *_Wr=1; all *_Flush=0.
REQ-018 In RUN, the block shall evaluate conditions in priority order: exception > D-cache miss > divide > load-use > branch; only the highest-priority active condition shall set the outputs, except per REQ-023.
REQ-019 Exception (MEM_ExcValid=1): ID_Flush=EXE_Flush=MEM_Flush=WB_Flush=1 and PC_Wr=1; next state EXC_FLUSH.
REQ-020 D-cache miss (DCache_Req=1, DCache_Ready=0): PC_Wr=ID_Wr=EXE_Wr=MEM_Wr=0 and WB_Flush=1; next state MEM_WAIT.
REQ-021 Divide (EXE_DivStart=1, Div_Done=0): PC_Wr=ID_Wr=EXE_Wr=0 and MEM_Flush=1; next state DIV_WAIT. If Div_Done=1 in the same cycle, there shall be no stall.
REQ-022 Load-use (EXE_IsLoad=1, EXE_Dst≠0, and EXE_Dst equal to ID_Rs or ID_Rt): PC_Wr=ID_Wr=0 and EXE_Flush=1; single cycle, state stays RUN.
REQ-023 Branch (EXE_BranchTaken=1): ID_Flush=1, which kills the IF instruction after the delay slot. This condition shall combine with load-use.
REQ-024 MEM_WAIT: the stall outputs of REQ-020 shall hold while DCache_Ready=0. On the DCache_Ready=1 cycle, outputs shall be the defaults and next state RUN. MEM_ExcValid shall be ignored in MEM_WAIT.
REQ-025 DIV_WAIT: the stall outputs of REQ-021 shall hold while Div_Done=0. On the Div_Done=1 cycle, outputs shall be the defaults and next state RUN.
REQ-026 EXC_FLUSH lasts exactly one cycle: ID_Flush=1, all *_Wr=1; next state RUN unconditionally.
REQ-027 After returning from MEM_WAIT, a still-asserted EXE_DivStart with Div_Done=0 shall enter DIV_WAIT on the next RUN cycle.
REQ-028 Stall_Cnt shall increment by 1 in each cycle with PC_Wr=0, saturate at 0xFFFF, and never wrap.
REQ-029 Cnt_Clr shall load 0 and take priority over the increment.
REQ-030 EXE_Dst=0 shall never cause a load-use stall.

Reset
REQ-031 When rst=0, Ctrl_State shall become RUN and Stall_Cnt shall become 0 immediately, regardless of clk.
REQ-032 While rst=0, outputs shall be the defaults.
REQ-033 Reset asserted in MEM_WAIT or DIV_WAIT shall abandon the wait. After release the block shall be in RUN.
REQ-034 There shall be no other internal state.

Verification
REQ-035 Load-use case: EXE_IsLoad=1, EXE_Dst=5, ID_Rt=5 for 1 cycle -> PC_Wr=ID_Wr=0 and EXE_Flush=1 that cycle; Ctrl_State=0; Stall_Cnt=1.
REQ-036 D-cache miss case: DCache_Req=1 with Ready=0 for 4 cycles, then Ready=1 -> Ctrl_State=1 for 4 cycles, all stalls plus WB_Flush in the first 4 cycles, defaults on the 5th cycle, then RUN; Stall_Cnt=4.
REQ-037 Simultaneous-event case: MEM_ExcValid=1 with a load-use hazard and EXE_BranchTaken=1 -> all four flushes, PC_Wr=1; next cycle Ctrl_State=3 with ID_Flush=1; following cycle RUN.
REQ-038 Divide case: EXE_DivStart=1 with Div_Done arriving after 10 cycles -> Ctrl_State=2 for 10 cycles with MEM_Flush=1 throughout; Stall_Cnt=10. Repeat with Div_Done=1 on the first cycle -> no stall.
REQ-039 Reset mid-wait and saturation case: assert rst=0 in cycle 3 of DIV_WAIT -> Ctrl_State=0 and Stall_Cnt=0 asynchronously. Separately, force 70000 stall cycles -> Stall_Cnt=0xFFFF; then Cnt_Clr=1 -> 0.
REQ-040 Zero-register case: load-use with EXE_Dst=0 and ID_Rs=0 -> no stall; all outputs at defaults.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall/flush controller: resolves exception, D-cache miss,
// multicycle divide, load-use and taken-branch events into per-stage write/flush controls.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic [4:0]  EXE_Dst,
  input  logic        EXE_IsLoad,
  input  logic        EXE_BranchTaken,
  input  logic        EXE_DivStart,
  input  logic        Div_Done,
  input  logic        DCache_Req,
  input  logic        DCache_Ready,
  input  logic        MEM_ExcValid,
  input  logic        Cnt_Clr,
  output logic        PC_Wr,
  output logic        ID_Wr,
  output logic        EXE_Wr,
  output logic        MEM_Wr,
  output logic        WB_Wr,
  output logic        ID_Flush,
  output logic        EXE_Flush,
  output logic        MEM_Flush,
  output logic        WB_Flush,
  output logic [1:0]  Ctrl_State,
  output logic [15:0] Stall_Cnt
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    DIV_WAIT  = 2'd2,
    EXC_FLUSH = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic load_use, dcache_miss, div_stall;

  // r0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign load_use    = EXE_IsLoad && (EXE_Dst != 5'd0) &&
                       ((EXE_Dst == ID_Rs) || (EXE_Dst == ID_Rt));
  assign dcache_miss = DCache_Req && !DCache_Ready;
  assign div_stall   = EXE_DivStart && !Div_Done;

  assign Ctrl_State = state;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can leave
    // a value unassigned and infer a latch.
    PC_Wr     = 1'b1;
    ID_Wr     = 1'b1;
    EXE_Wr    = 1'b1;
    MEM_Wr    = 1'b1;
    WB_Wr     = 1'b1;
    ID_Flush  = 1'b0;
    EXE_Flush = 1'b0;
    MEM_Flush = 1'b0;
    WB_Flush  = 1'b0;
    state_nxt = state;

    // Held in reset, the controls stay at their pass-through defaults.
    if (rst) begin
      case (state)
        RUN: begin
          if (MEM_ExcValid) begin
            ID_Flush  = 1'b1;
            EXE_Flush = 1'b1;
            MEM_Flush = 1'b1;
            WB_Flush  = 1'b1;
            state_nxt = EXC_FLUSH;
          end else if (dcache_miss) begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Wr    = 1'b0;
            MEM_Wr    = 1'b0;
            WB_Flush  = 1'b1;
            state_nxt = MEM_WAIT;
          end else if (div_stall) begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Wr    = 1'b0;
            MEM_Flush = 1'b1;
            state_nxt = DIV_WAIT;
          end else begin
            // Load-use bubble and branch kill are independent and may coincide.
            if (load_use) begin
              PC_Wr     = 1'b0;
              ID_Wr     = 1'b0;
              EXE_Flush = 1'b1;
            end
            if (EXE_BranchTaken) ID_Flush = 1'b1;
          end
        end

        MEM_WAIT: begin
          if (!DCache_Ready) begin
            PC_Wr    = 1'b0;
            ID_Wr    = 1'b0;
            EXE_Wr   = 1'b0;
            MEM_Wr   = 1'b0;
            WB_Flush = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end

        DIV_WAIT: begin
          if (!Div_Done) begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Wr    = 1'b0;
            MEM_Flush = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end

        EXC_FLUSH: begin
          ID_Flush  = 1'b1;
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      state     <= RUN;
      Stall_Cnt <= '0;
    end else begin
      state <= state_nxt;
      if (Cnt_Clr)
        Stall_Cnt <= '0;
      else if (!PC_Wr && (Stall_Cnt != 16'hFFFF))
        Stall_Cnt <= Stall_Cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hand-computed vectors for each hazard class,
// wait states, asynchronous reset and stall-counter saturation.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_Rs, ID_Rt, EXE_Dst;
  logic        EXE_IsLoad, EXE_BranchTaken, EXE_DivStart, Div_Done;
  logic        DCache_Req, DCache_Ready, MEM_ExcValid, Cnt_Clr;
  logic        PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr;
  logic        ID_Flush, EXE_Flush, MEM_Flush, WB_Flush;
  logic [1:0]  Ctrl_State;
  logic [15:0] Stall_Cnt;

  int n_vec = 0;
  int n_bad = 0;

  // {PC,ID,EXE,MEM,WB}_Wr then {ID,EXE,MEM,WB}_Flush
  localparam logic [8:0] O_DEF   = 9'b11111_0000;
  localparam logic [8:0] O_LU    = 9'b00111_0100;
  localparam logic [8:0] O_LU_BR = 9'b00111_1100;
  localparam logic [8:0] O_BR    = 9'b11111_1000;
  localparam logic [8:0] O_DC    = 9'b00001_0001;
  localparam logic [8:0] O_DIV   = 9'b00011_0010;
  localparam logic [8:0] O_EXC   = 9'b11111_1111;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .EXE_Dst(EXE_Dst),
    .EXE_IsLoad(EXE_IsLoad), .EXE_BranchTaken(EXE_BranchTaken),
    .EXE_DivStart(EXE_DivStart), .Div_Done(Div_Done),
    .DCache_Req(DCache_Req), .DCache_Ready(DCache_Ready),
    .MEM_ExcValid(MEM_ExcValid), .Cnt_Clr(Cnt_Clr),
    .PC_Wr(PC_Wr), .ID_Wr(ID_Wr), .EXE_Wr(EXE_Wr), .MEM_Wr(MEM_Wr), .WB_Wr(WB_Wr),
    .ID_Flush(ID_Flush), .EXE_Flush(EXE_Flush), .MEM_Flush(MEM_Flush), .WB_Flush(WB_Flush),
    .Ctrl_State(Ctrl_State), .Stall_Cnt(Stall_Cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr, ID_Flush, EXE_Flush, MEM_Flush, WB_Flush};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_Rs = 0; ID_Rt = 0; EXE_Dst = 0;
    EXE_IsLoad = 0; EXE_BranchTaken = 0; EXE_DivStart = 0; Div_Done = 0;
    DCache_Req = 0; DCache_Ready = 0; MEM_ExcValid = 0; Cnt_Clr = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    DCache_Req = 1'b1;
    #2;
    check("reset_state", 32'(Ctrl_State), 32'd0);
    check("reset_cnt", 32'(Stall_Cnt), 32'd0);
    check("reset_outs_default", 32'(outs()), 32'(O_DEF));
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();

    // Load-use on Rt
    adv();
    EXE_IsLoad = 1; EXE_Dst = 5'd5; ID_Rt = 5'd5; ID_Rs = 5'd3;
    @(negedge clk);
    check("lu_outs", 32'(outs()), 32'(O_LU));
    check("lu_state", 32'(Ctrl_State), 32'd0);
    adv();
    clear_inputs();
    @(negedge clk);
    check("lu_cnt", 32'(Stall_Cnt), 32'd1);
    check("lu_after_outs", 32'(outs()), 32'(O_DEF));

    // Load-use on Rs combined with a taken branch
    adv();
    EXE_IsLoad = 1; EXE_Dst = 5'd7; ID_Rs = 5'd7; EXE_BranchTaken = 1;
    @(negedge clk);
    check("lu_br_outs", 32'(outs()), 32'(O_LU_BR));
    adv();
    clear_inputs();
    EXE_BranchTaken = 1;
    @(negedge clk);
    check("br_outs", 32'(outs()), 32'(O_BR));
    check("lu_br_cnt", 32'(Stall_Cnt), 32'd2);

    // Zero-register load must not stall
    adv();
    clear_inputs();
    EXE_IsLoad = 1; EXE_Dst = 5'd0; ID_Rs = 5'd0;
    @(negedge clk);
    check("zero_reg_outs", 32'(outs()), 32'(O_DEF));

    // Synchronous counter clear
    adv();
    clear_inputs();
    Cnt_Clr = 1;
    adv();
    Cnt_Clr = 0;
    @(negedge clk);
    check("cnt_clr", 32'(Stall_Cnt), 32'd0);

    // D-cache miss, 4 stall cycles; exception ignored while waiting
    adv();
    DCache_Req = 1; DCache_Ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("dc_outs_%0d", i), 32'(outs()), 32'(O_DC));
      check($sformatf("dc_state_%0d", i), 32'(Ctrl_State), (i == 0) ? 32'd0 : 32'd1);
      adv();
      MEM_ExcValid = 1;
    end
    DCache_Ready = 1;
    @(negedge clk);
    check("dc_ready_outs", 32'(outs()), 32'(O_DEF));
    check("dc_ready_state", 32'(Ctrl_State), 32'd1);
    adv();
    clear_inputs();
    @(negedge clk);
    check("dc_back_run", 32'(Ctrl_State), 32'd0);
    check("dc_cnt", 32'(Stall_Cnt), 32'd4);

    // Miss with a divide pending: miss wins, divide stalls once back in RUN
    adv();
    Cnt_Clr = 1;
    adv();
    Cnt_Clr = 0;
    DCache_Req = 1; EXE_DivStart = 1;
    @(negedge clk);
    check("dc_div_prio", 32'(outs()), 32'(O_DC));
    adv();
    DCache_Ready = 1;
    @(negedge clk);
    check("dc_div_ready", 32'(outs()), 32'(O_DEF));
    adv();
    DCache_Req = 0; DCache_Ready = 0;
    // Divide: RUN stall cycle + 9 DIV_WAIT stall cycles, Div_Done on the 11th
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("div_outs_%0d", i), 32'(outs()), 32'(O_DIV));
      check($sformatf("div_state_%0d", i), 32'(Ctrl_State), (i == 0) ? 32'd0 : 32'd2);
      adv();
    end
    Div_Done = 1;
    @(negedge clk);
    check("div_done_outs", 32'(outs()), 32'(O_DEF));
    check("div_done_state", 32'(Ctrl_State), 32'd2);
    adv();
    clear_inputs();
    @(negedge clk);
    check("div_back_run", 32'(Ctrl_State), 32'd0);
    check("div_cnt", 32'(Stall_Cnt), 32'd11);  // 1 miss cycle + 10 divide cycles

    // Divide completing in the same cycle: no stall
    adv();
    EXE_DivStart = 1; Div_Done = 1;
    @(negedge clk);
    check("div_fast_outs", 32'(outs()), 32'(O_DEF));
    adv();
    clear_inputs();
    @(negedge clk);
    check("div_fast_state", 32'(Ctrl_State), 32'd0);
    check("div_fast_cnt", 32'(Stall_Cnt), 32'd11);

    // Exception with load-use and branch: exception takes everything
    adv();
    MEM_ExcValid = 1; EXE_IsLoad = 1; EXE_Dst = 5'd5; ID_Rt = 5'd5; EXE_BranchTaken = 1;
    @(negedge clk);
    check("exc_outs", 32'(outs()), 32'(O_EXC));
    adv();
    clear_inputs();
    @(negedge clk);
    check("exc_flush_state", 32'(Ctrl_State), 32'd3);
    check("exc_flush_outs", 32'(outs()), 32'(O_BR));
    adv();
    @(negedge clk);
    check("exc_back_run", 32'(Ctrl_State), 32'd0);
    check("exc_cnt", 32'(Stall_Cnt), 32'd11);

    // Asynchronous reset in cycle 3 of DIV_WAIT
    adv();
    EXE_DivStart = 1;
    adv();
    adv();
    adv();
    check("div_wait3_state", 32'(Ctrl_State), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_state", 32'(Ctrl_State), 32'd0);
    check("async_rst_cnt", 32'(Stall_Cnt), 32'd0);
    check("async_rst_outs", 32'(outs()), 32'(O_DEF));
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    adv();
    @(negedge clk);
    check("post_rst_state", 32'(Ctrl_State), 32'd0);
    check("post_rst_outs", 32'(outs()), 32'(O_DEF));

    // Saturation: 70000 stall cycles, then clear while still stalled
    adv();
    DCache_Req = 1; DCache_Ready = 0;
    repeat (70000) adv();
    @(negedge clk);
    check("sat_cnt", 32'(Stall_Cnt), 32'hFFFF);
    check("sat_state", 32'(Ctrl_State), 32'd1);
    adv();
    Cnt_Clr = 1;
    @(negedge clk);
    check("sat_hold", 32'(Stall_Cnt), 32'hFFFF);
    adv();
    check("sat_clr", 32'(Stall_Cnt), 32'd0);
    Cnt_Clr = 0;
    DCache_Ready = 1;
    @(negedge clk);
    check("sat_ready_outs", 32'(outs()), 32'(O_DEF));
    adv();
    clear_inputs();
    @(negedge clk);
    check("sat_back_run", 32'(Ctrl_State), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
